mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified, variable-latency memory port between the hart's instruction-fetch requester and data (load/store) requester.
- Latches one request at a time and sequences it through an issue/wait FSM.
- Routes the response back to the requester that owns it.
- Sits between the hart and the realistic memory model that replaces the combinational imem/dmem ports in later phases.

Parameters:
- TIMEOUT_CYCLES, 16'd256: max cycles in ISSUE+WAIT before forced error response; 0 disables timeout.
- RESET_ADDR_UNUSED_W, 2: number of address LSBs forced to zero on o_mem_addr (word alignment).

Ports:
- i_clk  in  1  global clock
- i_rst  in  1  asynchronous active-high reset
- i_if_req  in  1  fetch request valid
- i_if_addr  in  32  fetch address
- o_if_gnt  out  1  fetch request accepted this cycle (combinational, IDLE only)
- o_if_rvalid  out  1  fetch response valid, one-cycle pulse
- o_if_rdata  out  32  fetch response word
- o_if_err  out  1  fetch response is a timeout error
- i_d_req  in  1  data request valid
- i_d_wen  in  1  1 = store, 0 = load
- i_d_addr  in  32  data address
- i_d_wdata  in  32  store data, pre-shifted into byte lanes
- i_d_mask  in  4  byte-lane mask
- o_d_gnt  out  1  data request accepted this cycle
- o_d_rvalid  out  1  data response/store-complete pulse
- o_d_rdata  out  32  load response word
- o_d_err  out  1  data response is a timeout error
- o_mem_valid  out  1  request valid to memory
- i_mem_ready  in  1  memory accepts request
- o_mem_addr  out  32  aligned address
- o_mem_wen  out  1  write enable
- o_mem_wdata  out  32  write data
- o_mem_mask  out  4  byte mask; 4'b1111 for fetch
- i_mem_rvalid  in  1  memory response valid (reads and write acks)
- i_mem_rdata  in  32  memory read data
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, any state): FSM=IDLE. All outputs 0. Latched request, owner flag and timeout counter cleared. Any in-flight transaction is abandoned; no response pulse is emitted.
- IDLE:
  - If i_d_req: o_d_gnt=1; latch data fields, owner=DATA.
  - Else if i_if_req: o_if_gnt=1; latch fetch fields, owner=IF, wen=0, mask=4'b1111.
  - On grant, go to ISSUE next edge. Never grant both in one cycle.
- ISSUE: o_mem_valid=1 with latched fields, held stable until i_mem_ready. On valid&&ready, go to WAIT.
- WAIT: on i_mem_rvalid, go to IDLE. Next cycle the owner's rvalid pulses for exactly 1 cycle with rdata=i_mem_rdata captured (store: rdata=0). A new grant is permitted in that same cycle.
- i_mem_rvalid in IDLE or ISSUE is ignored (stray).
- Latency: grant at cycle N, o_mem_valid at N+1. With i_mem_ready at N+1 and i_mem_rvalid at N+2, o_*_rvalid is at N+3. Minimum throughput: 1 transaction per 3 cycles.
- o_mem_addr = latched addr with low 2 bits zeroed. Unaligned requests are the hart's responsibility (trap before request).
- Timeout: a 16-bit counter clears on grant and increments each cycle in ISSUE/WAIT.
  - When it equals TIMEOUT_CYCLES (nonzero): go to IDLE; owner gets rvalid=1, err=1, rdata=0 next cycle. o_mem_valid drops.
  - A later late i_mem_rvalid is ignored.
- Requesters must hold req/fields until gnt. The arbiter does not queue; gnt is the only acceptance.
- o_*_rdata/o_*_err hold their last value between pulses; they are meaningful only when rvalid=1.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined: round-robin priority. A 1-bit last-owner register (reset to IF) gives priority to the requester not served last when both request in IDLE.
- Undefined: fixed data-over-fetch priority as above; no last-owner register.

Test Plan:
- Single fetch: i_if_req, addr=32'h0000_0103; ready same cycle, rvalid 1 cycle later with rdata=32'hDEAD_BEEF -> o_mem_addr=32'h0000_0100, mask=4'b1111; o_if_rvalid 3 cycles after gnt with rdata DEADBEEF, err=0.
- Conflict: i_if_req and i_d_req (load 0x2000) same cycle -> o_d_gnt first, o_if_gnt in the cycle o_d_rvalid pulses. With MEM_ARBITER_RR_EN and a preceding data transaction, fetch is granted first.
- Backpressure: i_mem_ready low 5 cycles during a sb (mask 4'b1000, wdata 32'hAB00_0000) -> o_mem_* stable all 5 cycles; one o_d_rvalid after ack.
- Timeout: TIMEOUT_CYCLES=8, memory never responds -> o_d_rvalid=1, o_d_err=1, rdata=0. A late i_mem_rvalid produces no pulse.
- Async reset asserted mid-WAIT -> outputs 0 immediately, o_busy=0. No rvalid after release. The next request is granted normally.
- Stray i_mem_rvalid in IDLE -> no rvalid pulse on either side.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Purpose : groups the fetch requester, data requester and unified memory port
//           signals seen by mem_arbiter into one bundle.
// Signals :
//   fetch  : i_if_req, i_if_addr -> o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err
//   data   : i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask
//            -> o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err
//   memory : o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask
//            <- i_mem_ready, i_mem_rvalid, i_mem_rdata
//   status : o_busy
// Modports: slave  - the arbiter itself (drives every o_* signal)
//           master - the surrounding hart/memory environment (drives i_*)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        o_if_err;

  logic        i_d_req;
  logic        i_d_wen;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [3:0]  i_d_mask;
  logic        o_d_gnt;
  logic        o_d_rvalid;
  logic [31:0] o_d_rdata;
  logic        o_d_err;

  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  logic        o_busy;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
    input  i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    output o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
    output o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_busy
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
    output i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    input  o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
    input  o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Purpose : shares one variable-latency memory port between the instruction
//           fetch requester and the data (load/store) requester. One request
//           is latched at a time and walked through IDLE -> ISSUE -> WAIT; the
//           response is routed back to whichever requester owns it.
// Ports   : i_clk  - clock
//           i_rst  - asynchronous active-high reset
//           bus    - mem_arbiter_if.slave (fetch, data, memory and busy signals)
// Params  : TIMEOUT_CYCLES      - cycles in ISSUE/WAIT before a forced error
//                                 response (0 disables the timeout)
//           RESET_ADDR_UNUSED_W - address LSBs forced to zero on o_mem_addr
// Macro   : MEM_ARBITER_RR_EN - when defined, round-robin priority between the
//           two requesters; otherwise data always wins over fetch.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES      = 16'd256,
  parameter int          RESET_ADDR_UNUSED_W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic OWNER_IF   = 1'b0;
  localparam logic OWNER_DATA = 1'b1;
  localparam logic [31:0] ADDR_KEEP = ~((32'd1 << RESET_ADDR_UNUSED_W) - 32'd1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] cnt_q, cnt_d;

  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_err_q, if_err_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;

  logic        pick_data;
  logic        if_gnt, d_gnt;
  logic        timeout_hit;
  logic        respond, respond_err;

`ifdef MEM_ARBITER_RR_EN
  logic last_q, last_d;
  // On contention, serve data only if fetch was the last one served.
  assign pick_data = bus.i_d_req && (!bus.i_if_req || (last_q == OWNER_IF));
`else
  assign pick_data = bus.i_d_req;
`endif

  assign timeout_hit = (TIMEOUT_CYCLES != 16'd0) && (cnt_q == TIMEOUT_CYCLES);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = wen_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    respond     = 1'b0;
    respond_err = 1'b0;
`ifdef MEM_ARBITER_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is held so every output reads 0.
        if (!i_rst && pick_data) begin
          d_gnt   = 1'b1;
          owner_d = OWNER_DATA;
          addr_d  = bus.i_d_addr;
          wdata_d = bus.i_d_wdata;
          wen_d   = bus.i_d_wen;
          mask_d  = bus.i_d_mask;
          cnt_d   = 16'd0;
          state_d = ISSUE;
`ifdef MEM_ARBITER_RR_EN
          last_d  = OWNER_DATA;
`endif
        end else if (!i_rst && bus.i_if_req) begin
          if_gnt  = 1'b1;
          owner_d = OWNER_IF;
          addr_d  = bus.i_if_addr;
          wdata_d = 32'd0;
          wen_d   = 1'b0;
          mask_d  = 4'b1111;
          cnt_d   = 16'd0;
          state_d = ISSUE;
`ifdef MEM_ARBITER_RR_EN
          last_d  = OWNER_IF;
`endif
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 16'd1;
        if (timeout_hit) begin
          respond     = 1'b1;
          respond_err = 1'b1;
          state_d     = IDLE;
        end else if (bus.i_mem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A real response arriving on the timeout cycle still wins.
        if (bus.i_mem_rvalid) begin
          respond = 1'b1;
          state_d = IDLE;
        end else if (timeout_hit) begin
          respond     = 1'b1;
          respond_err = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response registers: each side keeps its last rdata/err between pulses.
  always_comb begin
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;
    if (respond) begin
      if (owner_q == OWNER_DATA) begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = (respond_err || wen_q) ? 32'd0 : bus.i_mem_rdata;
        d_err_d    = respond_err;
      end else begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = respond_err ? 32'd0 : bus.i_mem_rdata;
        if_err_d    = respond_err;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_IF;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wen_q       <= 1'b0;
      mask_q      <= 4'd0;
      cnt_q       <= 16'd0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'd0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) last_q <= OWNER_IF;
    else       last_q <= last_d;
  end
`endif

  assign bus.o_if_gnt    = if_gnt;
  assign bus.o_d_gnt     = d_gnt;
  assign bus.o_if_rvalid = if_rvalid_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_if_err    = if_err_q;
  assign bus.o_d_rvalid  = d_rvalid_q;
  assign bus.o_d_rdata   = d_rdata_q;
  assign bus.o_d_err     = d_err_q;
  assign bus.o_mem_valid = (state_q == ISSUE);
  assign bus.o_mem_addr  = addr_q & ADDR_KEEP;
  assign bus.o_mem_wen   = wen_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_mem_mask  = mask_q;
  assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(16'd8), .RESET_ADDR_UNUSED_W(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          is_d;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          rdy_dly;
    logic [31:0] mem_rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_if_req     = 1'b0;
    bus.i_if_addr    = 32'h0;
    bus.i_d_req      = 1'b0;
    bus.i_d_wen      = 1'b0;
    bus.i_d_addr     = 32'h0;
    bus.i_d_wdata    = 32'h0;
    bus.i_d_mask     = 4'h0;
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 32'h0;
  endtask

  // Pop the oldest expectation and compare it to the response now visible.
  task automatic pop_compare(input string tag);
    exp_t e;
    if (!(bus.o_if_rvalid || bus.o_d_rvalid)) begin
      checks++; failures++;
      $display("FAIL %s_resp_missing actual=none required=pulse", tag);
    end else if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_resp_unexpected actual=pulse required=none", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_side"}, {30'd0, bus.o_d_rvalid, bus.o_if_rvalid}, e.is_d ? 32'd2 : 32'd1);
      chk({tag, "_rdata"}, e.is_d ? bus.o_d_rdata : bus.o_if_rdata, e.rdata);
      chk({tag, "_err"}, {31'd0, e.is_d ? bus.o_d_err : bus.o_if_err}, {31'd0, e.err});
      $display("txn %s owner=%s rdata=%h err=%0d", tag, e.is_d ? "D" : "IF",
               e.is_d ? bus.o_d_rdata : bus.o_if_rdata,
               e.is_d ? bus.o_d_err : bus.o_if_err);
    end
  endtask

  task automatic set_req(input vec_t v);
    if (v.is_d) begin
      bus.i_d_req   = 1'b1;
      bus.i_d_wen   = v.wen;
      bus.i_d_addr  = v.addr;
      bus.i_d_wdata = v.wdata;
      bus.i_d_mask  = v.mask;
    end else begin
      bus.i_if_req  = 1'b1;
      bus.i_if_addr = v.addr;
      // Junk on the idle data lanes must not leak into a fetch.
      bus.i_d_wen   = 1'b1;
      bus.i_d_wdata = 32'h5555_AAAA;
      bus.i_d_mask  = 4'b0101;
    end
  endtask

  task automatic check_mem(input string tag, input vec_t v);
    chk({tag, "_mem_valid"}, {31'd0, bus.o_mem_valid}, 32'd1);
    chk({tag, "_mem_addr"}, bus.o_mem_addr, v.exp_addr);
    chk({tag, "_mem_mask"}, {28'd0, bus.o_mem_mask}, {28'd0, v.exp_mask});
    chk({tag, "_mem_wen"}, {31'd0, bus.o_mem_wen}, {31'd0, v.wen});
    if (v.is_d) chk({tag, "_mem_wdata"}, bus.o_mem_wdata, v.wdata);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int   t0;
    exp_t e;
    @(negedge clk);
    set_req(v);
    #1;
    chk({tag, "_gnt"}, {30'd0, bus.o_d_gnt, bus.o_if_gnt}, v.is_d ? 32'd2 : 32'd1);
    t0 = cyc;
    e.is_d = v.is_d; e.rdata = v.exp_rdata; e.err = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    clear_inputs();
    check_mem(tag, v);
    for (int k = 0; k < v.rdy_dly; k++) begin
      @(negedge clk);
      check_mem({tag, "_hold"}, v);
    end
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    bus.i_mem_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, bus.o_mem_valid}, 32'd0);
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = v.mem_rdata;
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 32'h0BAD_0BAD;
    pop_compare(tag);
    chk({tag, "_latency"}, cyc - t0, 3 + v.rdy_dly);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {30'd0, bus.o_d_rvalid, bus.o_if_rvalid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   found;
    exp_t e;
    vec_t a, b;

    //            is_d wen addr           wdata          mask    dly rdata          exp_addr       mask    exp_rdata
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0103, 32'h0,         4'h0,    0, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'b1111, 0, 32'h1234_5678, 32'h0000_2000, 4'b1111, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_3003, 32'hAB00_0000, 4'b1000, 5, 32'hFFFF_FFFF, 32'h0000_3000, 4'b1000, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0,         4'h0,    2, 32'hA5A5_5A5A, 32'hFFFF_FFFC, 4'b1111, 32'hA5A5_5A5A};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 1, 32'h7777_7777, 32'h0000_0040, 4'b1111, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_1001, 32'h0,         4'b0011, 0, 32'h0000_BEEF, 32'h0000_1000, 4'b0011, 32'h0000_BEEF};

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_mem_valid", {31'd0, bus.o_mem_valid}, 32'd0);
    chk("rst_mem_addr", bus.o_mem_addr, 32'd0);
    chk("rst_rvalid", {30'd0, bus.o_d_rvalid, bus.o_if_rvalid}, 32'd0);
    chk("rst_rdata", bus.o_if_rdata | bus.o_d_rdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Conflict: both request together; the previous transaction was data.
    a = vecs[1]; a.addr = 32'h0000_2000; a.exp_addr = 32'h0000_2000; a.exp_rdata = 32'h1111_2222;
    b = vecs[0]; b.addr = 32'h0000_0500; b.exp_addr = 32'h0000_0500; b.exp_rdata = 32'h3333_4444;
    @(negedge clk);
    set_req(a);
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = b.addr;
    #1;
    chk("conflict_first_gnt", {30'd0, bus.o_d_gnt, bus.o_if_gnt}, RR ? 32'd1 : 32'd2);
    e.is_d = !RR; e.rdata = RR ? 32'h3333_4444 : 32'h1111_2222; e.err = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    if (RR) bus.i_if_req = 1'b0; else bus.i_d_req = 1'b0;
    chk("conflict_first_addr", bus.o_mem_addr, RR ? 32'h0000_0500 : 32'h0000_2000);
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = e.rdata;
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0;
    #1;
    pop_compare("conflict_first");
    chk("conflict_second_gnt", {30'd0, bus.o_d_gnt, bus.o_if_gnt}, RR ? 32'd2 : 32'd1);
    e.is_d = RR; e.rdata = RR ? 32'h1111_2222 : 32'h3333_4444; e.err = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    bus.i_if_req = 1'b0; bus.i_d_req = 1'b0;
    chk("conflict_second_addr", bus.o_mem_addr, RR ? 32'h0000_2000 : 32'h0000_0500);
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = e.rdata;
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0;
    pop_compare("conflict_second");
    clear_inputs();

    // Timeout: memory accepts a load but never answers.
    @(negedge clk);
    a = vecs[1]; a.addr = 32'h0000_4000;
    set_req(a);
    #1;
    chk("tmo_gnt", {31'd0, bus.o_d_gnt}, 32'd1);
    e.is_d = 1'b1; e.rdata = 32'h0; e.err = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    clear_inputs();
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    bus.i_mem_ready = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (bus.o_d_rvalid || bus.o_if_rvalid) found = 1'b1;
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL tmo_expired actual=no_pulse required=err_pulse");
    end else begin
      pop_compare("tmo");
      chk("tmo_valid_low", {31'd0, bus.o_mem_valid}, 32'd0);
      chk("tmo_idle", {31'd0, bus.o_busy}, 32'd0);
    end
    @(negedge clk);
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h9999_9999;
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0;
    chk("tmo_late_ignored", {30'd0, bus.o_d_rvalid, bus.o_if_rvalid}, 32'd0);

    // Reset mid-WAIT: fetch in flight is abandoned without a response.
    @(negedge clk);
    a = vecs[0]; a.addr = 32'h0000_0600;
    set_req(a);
    #1;
    chk("rstw_gnt", {31'd0, bus.o_if_gnt}, 32'd1);
    @(negedge clk);
    clear_inputs();
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    bus.i_mem_ready = 1'b0;
    chk("rstw_busy_before", {31'd0, bus.o_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rstw_mem_valid", {31'd0, bus.o_mem_valid}, 32'd0);
    chk("rstw_mem_addr", bus.o_mem_addr, 32'd0);
    chk("rstw_d_rdata", bus.o_d_rdata, 32'd0);
    chk("rstw_d_err", {31'd0, bus.o_d_err}, 32'd0);
    chk("rstw_if_rdata", bus.o_if_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Stray response while IDLE.
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h4242_4242;
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0;
    chk("stray_idle_a", {30'd0, bus.o_d_rvalid, bus.o_if_rvalid}, 32'd0);
    @(negedge clk);
    chk("stray_idle_b", {30'd0, bus.o_d_rvalid, bus.o_if_rvalid}, 32'd0);

    run_vec("post_rst", vecs[0]);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
